// File: rtl/control_obstaculos.sv
// Game logic: play-state FSM, per-frame obstacle/player motion and collision detect for the painter.
// Latency: positions 1 clk after iFrame, CHOQUE 1 clk after overlap; no backpressure, iFrame is never stalled.
module control_obstaculos #(
    parameter int Y_JUGADOR     = 390,
    parameter int ANCHO         = 65,
    parameter int ALTO          = 70,
    parameter int FRAMES_CHOQUE = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iFrame,
    input  logic        iIzquierda,
    input  logic        iDerecha,
    input  logic        iInicio,
    output logic        oPintarCarros,
    output logic        oPintarJugador,
    output logic [9:0]  oPosicionX1,
    output logic [9:0]  oPosicionX2,
    output logic [9:0]  oPosicionX3,
    output logic [8:0]  oPosicionY1,
    output logic [8:0]  oPosicionY2,
    output logic [8:0]  oPosicionJugador,
    output logic [15:0] oPuntaje,
    output logic        oChoque
);
    typedef enum logic [1:0] {INICIO, JUGANDO, CHOQUE} estado_t;

    localparam logic [9:0] CARRIL0    = 10'd215;
    localparam logic [9:0] CARRIL1    = 10'd278;
    localparam logic [9:0] CARRIL2    = 10'd340;
    localparam logic [8:0] JUG_MIN    = 9'd215;
    localparam logic [8:0] JUG_MAX    = 9'd340;
    localparam logic [8:0] JUG_INI    = 9'd278;
    localparam logic [9:0] Y_JUG      = 10'(Y_JUGADOR);
    localparam logic [9:0] Y_JUG_FIN  = 10'(Y_JUGADOR + ALTO);
    localparam logic [9:0] ANCHO_W    = 10'(ANCHO);
    localparam logic [9:0] ALTO_W     = 10'(ALTO);
    localparam logic [9:0] Y_PANTALLA = 10'd480;
    localparam logic [9:0] Y_CARRIL3  = 10'd410;
    localparam logic [7:0] CHOQUE_ULT = 8'(FRAMES_CHOQUE - 1);

    estado_t    estado;
    logic [7:0] lfsr;
    logic [7:0] cuentaFrames;
    logic [7:0] cuentaChoque;
    logic [3:0] velocidad;
    logic       inicioPrev;

    logic [9:0] carrilLfsr;
    logic [9:0] y1Ext, y2Ext, xJug;
    logic [9:0] y1Suma, y2Suma;
    logic       wrap1, wrap2, cruce3;
    logic       choque1, choque2, hayChoque;
    logic       flancoInicio, salidaChoque;

    // Lane code 3 folds onto the centre lane.
    always_comb begin
        case (lfsr[1:0])
            2'd0:    carrilLfsr = CARRIL0;
            2'd2:    carrilLfsr = CARRIL2;
            default: carrilLfsr = CARRIL1;
        endcase
    end

    assign y1Ext  = {1'b0, oPosicionY1};
    assign y2Ext  = {1'b0, oPosicionY2};
    assign xJug   = {1'b0, oPosicionJugador};
    assign y1Suma = y1Ext + {6'd0, velocidad};
    assign y2Suma = y2Ext + {6'd0, velocidad};
    assign wrap1  = (y1Suma >= Y_PANTALLA);
    assign wrap2  = (y2Suma >= Y_PANTALLA);
    assign cruce3 = (y1Ext <= Y_CARRIL3) && (y1Suma > Y_CARRIL3) && !wrap1;

    // Strict inequalities so a hit is exactly a pixel overlap on the painter.
    assign choque1 = (y1Ext < Y_JUG_FIN) && (y1Ext + ALTO_W > Y_JUG)
                  && (oPosicionX1 < xJug + ANCHO_W) && (oPosicionX1 + ANCHO_W > xJug);
    assign choque2 = (y2Ext < Y_JUG_FIN) && (y2Ext + ALTO_W > Y_JUG)
                  && (oPosicionX2 < xJug + ANCHO_W) && (oPosicionX2 + ANCHO_W > xJug);
    assign hayChoque = choque1 || choque2;

    assign flancoInicio = iInicio && !inicioPrev;
    assign salidaChoque = (estado == CHOQUE)
                       && (flancoInicio || (iFrame && cuentaChoque == CHOQUE_ULT));

    always_ff @(posedge clk) begin
        if (reset) begin
            estado         <= INICIO;
            lfsr           <= 8'hA5;
            inicioPrev     <= 1'b0;
            oPintarCarros  <= 1'b0;
            oPintarJugador <= 1'b1;
            oChoque        <= 1'b0;
            oPuntaje       <= 16'd0;
            cuentaFrames   <= 8'd0;
            cuentaChoque   <= 8'd0;
        end else begin
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            inicioPrev <= iInicio;
            case (estado)
                INICIO: begin
                    if (iInicio) begin
                        estado        <= JUGANDO;
                        oPintarCarros <= 1'b1;
                        oPuntaje      <= 16'd0;
                        cuentaFrames  <= 8'd0;
                    end
                end
                JUGANDO: begin
                    if (hayChoque) begin
                        estado       <= CHOQUE;
                        oChoque      <= 1'b1;
                        cuentaChoque <= 8'd0;
                    end else if (iFrame) begin
                        oPosicionY1 <= wrap1 ? 9'(y1Suma - Y_PANTALLA) : y1Suma[8:0];
                        oPosicionY2 <= wrap2 ? 9'(y2Suma - Y_PANTALLA) : y2Suma[8:0];
                        if (wrap1)
                            oPosicionX1 <= oPosicionX3;
                        if (wrap2)
                            oPosicionX2 <= carrilLfsr;
                        if (cruce3)
                            oPosicionX3 <= carrilLfsr;
                        oPuntaje <= oPuntaje + 16'(wrap1) + 16'(wrap2);
                        if (iIzquierda && !iDerecha)
                            oPosicionJugador <= (oPosicionJugador <= JUG_MIN + 9'd4)
                                              ? JUG_MIN : oPosicionJugador - 9'd4;
                        else if (iDerecha && !iIzquierda)
                            oPosicionJugador <= (oPosicionJugador >= JUG_MAX - 9'd4)
                                              ? JUG_MAX : oPosicionJugador + 9'd4;
                        cuentaFrames <= cuentaFrames + 8'd1;
                        if (cuentaFrames == 8'hFF && velocidad < 4'd8)
                            velocidad <= velocidad + 4'd1;
                    end
                end
                CHOQUE: begin
                    if (iFrame)
                        cuentaChoque <= cuentaChoque + 8'd1;
                    if (salidaChoque) begin
                        estado        <= INICIO;
                        oPintarCarros <= 1'b0;
                        oChoque       <= 1'b0;
                    end
                end
                default: estado <= INICIO;
            endcase
        end

        // Reset and the crash-screen exit share the same starting layout.
        if (reset || salidaChoque) begin
            oPosicionX1      <= CARRIL0;
            oPosicionX2      <= CARRIL2;
            oPosicionX3      <= CARRIL1;
            oPosicionY1      <= 9'd0;
            oPosicionY2      <= 9'd240;
            oPosicionJugador <= JUG_INI;
            velocidad        <= 4'd2;
        end
    end
endmodule

// File: tb/tb_control_obstaculos.sv
// Bench for control_obstaculos: directed scenarios plus a randomized game against a frame-level model.
module tb_control_obstaculos;
    localparam int YJ = 390;
    localparam int AN = 65;
    localparam int AL = 70;
    localparam int FC = 120;

    logic        clk = 1'b0;
    logic        reset, iFrame, iIzquierda, iDerecha, iInicio;
    logic        oPintarCarros, oPintarJugador, oChoque;
    logic [9:0]  oPosicionX1, oPosicionX2, oPosicionX3;
    logic [8:0]  oPosicionY1, oPosicionY2, oPosicionJugador;
    logic [15:0] oPuntaje;

    int total = 0;
    int bad   = 0;

    control_obstaculos dut (
        .clk(clk), .reset(reset), .iFrame(iFrame),
        .iIzquierda(iIzquierda), .iDerecha(iDerecha), .iInicio(iInicio),
        .oPintarCarros(oPintarCarros), .oPintarJugador(oPintarJugador),
        .oPosicionX1(oPosicionX1), .oPosicionX2(oPosicionX2), .oPosicionX3(oPosicionX3),
        .oPosicionY1(oPosicionY1), .oPosicionY2(oPosicionY2),
        .oPosicionJugador(oPosicionJugador), .oPuntaje(oPuntaje), .oChoque(oChoque)
    );

    always #5 clk = ~clk;

    // Reference model: game modes and plain integer positions.
    localparam int M_IDLE = 0, M_PLAY = 1, M_CRASH = 2;
    int          carril [4] = '{215, 278, 340, 278};
    int          mModo, mX1, mX2, mX3, mY1, mY2, mXp, mFrames, mChoqueFr;
    logic [15:0] mScore;
    logic [7:0]  mLfsr;
    bit          mPrevIni;

    task automatic chequear(input string tag, input longint obs, input longint esp);
        total++;
        if (obs != esp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, esp, $time);
        end
    endtask

    function automatic bit solapa(input int x, input int y, input int xp);
        return (y < YJ + AL) && (y + AL > YJ) && (x < xp + AN) && (x + AN > xp);
    endfunction

    task automatic layoutInicial();
        mX1 = 215; mX2 = 340; mX3 = 278; mY1 = 0; mY2 = 240; mXp = 278;
    endtask

    task automatic pasoModelo();
        int lane, vel, y1n, y2n;
        bit sube;
        lane = carril[mLfsr[1:0]];
        sube = iInicio && !mPrevIni;
        if (reset) begin
            mModo = M_IDLE; layoutInicial(); mScore = 0; mLfsr = 8'hA5; mPrevIni = 0;
        end else begin
            if (mModo == M_IDLE) begin
                if (iInicio) begin mModo = M_PLAY; mScore = 0; mFrames = 0; end
            end else if (mModo == M_PLAY) begin
                if (solapa(mX1, mY1, mXp) || solapa(mX2, mY2, mXp)) begin
                    mModo = M_CRASH; mChoqueFr = 0;
                end else if (iFrame) begin
                    vel = 2 + mFrames / 256;
                    if (vel > 8) vel = 8;
                    y1n = mY1 + vel;
                    y2n = mY2 + vel;
                    if (mY1 <= 410 && y1n > 410 && y1n < 480) mX3 = lane;
                    if (y1n >= 480) begin mX1 = mX3; mScore = mScore + 1; end
                    if (y2n >= 480) begin mX2 = lane; mScore = mScore + 1; end
                    mY1 = y1n % 480;
                    mY2 = y2n % 480;
                    if (iIzquierda && !iDerecha) mXp = (mXp - 4 < 215) ? 215 : mXp - 4;
                    if (iDerecha && !iIzquierda) mXp = (mXp + 4 > 340) ? 340 : mXp + 4;
                    mFrames++;
                end
            end else begin
                if (iFrame) mChoqueFr++;
                if (sube || mChoqueFr == FC) begin mModo = M_IDLE; layoutInicial(); end
            end
            mLfsr = {mLfsr[6:0], ^(mLfsr & 8'hB8)};
            mPrevIni = iInicio;
        end
    endtask

    task automatic compararTodo();
        chequear("pintarCarros", oPintarCarros, mModo != M_IDLE);
        chequear("pintarJugador", oPintarJugador, 1);
        chequear("choque", oChoque, mModo == M_CRASH);
        chequear("x1", oPosicionX1, mX1);
        chequear("x2", oPosicionX2, mX2);
        chequear("x3", oPosicionX3, mX3);
        chequear("y1", oPosicionY1, mY1);
        chequear("y2", oPosicionY2, mY2);
        chequear("jugador", oPosicionJugador, mXp);
        chequear("puntaje", oPuntaje, mScore);
    endtask

    task automatic tick(input bit fr, input bit izq, input bit der, input bit ini, input bit rst);
        iFrame = fr; iIzquierda = izq; iDerecha = der; iInicio = ini; reset = rst;
        @(posedge clk);
        pasoModelo();
        @(negedge clk);
        compararTodo();
    endtask

    // Dodge the nearest obstacle still above the player's bottom edge.
    function automatic bit [1:0] politica();
        int ax, ay, objetivo;
        ax = -1; ay = -1; objetivo = mXp;
        if (mY1 < YJ + AL && mY1 > ay) begin ax = mX1; ay = mY1; end
        if (mY2 < YJ + AL && mY2 > ay) begin ax = mX2; ay = mY2; end
        if (ax == 340) objetivo = 215;
        else if (ax == 215) objetivo = 340;
        return {objetivo < mXp, objetivo > mXp};
    endfunction

    initial begin
        int holdIni, yv, xv;
        bit visto;
        bit [1:0] btn;
        iFrame = 0; iIzquierda = 0; iDerecha = 0; iInicio = 0; reset = 1;
        mLfsr = 8'hA5; mModo = M_IDLE; layoutInicial(); mScore = 0; mPrevIni = 0;
        mFrames = 0; mChoqueFr = 0;

        // Reset and idle frames
        repeat (3) tick(0, 0, 0, 0, 1);
        repeat (10) begin tick(1, 0, 0, 0, 0); tick(0, 0, 0, 0, 0); end
        chequear("idleX1", oPosicionX1, 215);
        chequear("idleX2", oPosicionX2, 340);
        chequear("idleX3", oPosicionX3, 278);
        chequear("idleY1", oPosicionY1, 0);
        chequear("idleY2", oPosicionY2, 240);
        chequear("idleJug", oPosicionJugador, 278);
        chequear("idleCarros", oPintarCarros, 0);
        chequear("idleChoque", oChoque, 0);

        // Start and first frame
        tick(0, 0, 0, 1, 0);
        chequear("startCarros", oPintarCarros, 1);
        tick(1, 0, 0, 0, 0);
        chequear("frame1Y1", oPosicionY1, 2);
        chequear("frame1Y2", oPosicionY2, 242);

        // Player clamp left, then both buttons
        repeat (30) tick(1, 1, 0, 0, 0);
        chequear("clampIzq", oPosicionJugador, 215);
        repeat (5) tick(1, 1, 1, 0, 0);
        chequear("ambosBotones", oPosicionJugador, 215);

        // Collision: fresh game, park player at 340, let obstacle 2 step into it
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 1, 0);
        visto = 0;
        for (int i = 0; i < 200 && !visto; i++) begin
            tick(1, 0, 1, 0, 0);
            if (solapa(mX2, mY2, mXp) || solapa(mX1, mY1, mXp)) visto = 1;
        end
        chequear("solapeAlcanzado", visto, 1);
        chequear("solapeJugador", oPosicionJugador, 340);
        chequear("choqueAntes", oChoque, 0);
        yv = oPosicionY2; xv = oPosicionJugador;
        tick(1, 0, 1, 0, 0);
        chequear("choqueLatencia", oChoque, 1);
        chequear("congeladoY2", oPosicionY2, yv);
        tick(1, 1, 0, 0, 0);
        chequear("congeladoJug", oPosicionJugador, xv);

        // Crash timeout after FC frame pulses (one already counted above)
        repeat (FC - 2) begin tick(1, 0, 0, 0, 0); tick(0, 0, 0, 0, 0); end
        chequear("choqueSigue", oChoque, 1);
        tick(1, 0, 0, 0, 0);
        chequear("timeoutChoque", oChoque, 0);
        chequear("timeoutY2", oPosicionY2, 240);
        chequear("timeoutJug", oPosicionJugador, 278);

        // Held start button does not restart from CHOQUE; reset mid-crash
        tick(0, 0, 0, 1, 0);
        for (int i = 0; i < 400 && mModo != M_CRASH; i++) tick(1, 0, 0, 1, 0);
        repeat (5) tick(1, 0, 0, 1, 0);
        chequear("mantenidoSinReinicio", oChoque, 1);
        tick(1, 0, 0, 0, 1);
        chequear("resetChoque", oChoque, 0);
        chequear("resetPuntaje", oPuntaje, 0);
        chequear("resetCarros", oPintarCarros, 0);

        // Randomized play against the model
        holdIni = 0;
        for (int c = 0; c < 40000 && bad < 100; c++) begin
            if (holdIni > 0) holdIni--;
            else if ($urandom_range(0, 299) == 0) holdIni = int'($urandom_range(1, 300));
            if ($urandom_range(0, 6) == 0) btn = 2'($urandom_range(0, 3));
            else btn = politica();
            tick(1'($urandom_range(0, 1)), btn[1], btn[0], holdIni > 0,
                 $urandom_range(0, 4999) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
